open_list_ctrl: RTL and testbench

Controller that turns the `updateQueue` cost memory into the A* open list, a small priority queue. It keeps a per-slot valid bitmap and an occupancy count, and serves four commands through a valid/ready handshake: INSERT, POP_MIN, UPDATE (decrease-key) and CLEAR. It sequences every memory access, including a full linear scan for extract-min. It sits between the A* search FSM and one `updateQueue` instance, and is the only master of that memory.

---
 rtl/open_list_pkg.sv | 32 +++
 rtl/open_list_if.sv | 31 +++
 rtl/free_slot_enc.sv | 23 ++
 rtl/open_list_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_open_list_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/open_list_pkg.sv
// Shared types for the A* open-list controller: command opcodes, FSM states
// and the response record.
package open_list_pkg;

  localparam int OL_DATA_WIDTH = 8;
  localparam int OL_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_INSERT  = 2'b00,
    OP_POP_MIN = 2'b01,
    OP_UPDATE  = 2'b10,
    OP_CLEAR   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INS_WR,
    ST_SCAN,
    ST_SCAN_DRAIN,
    ST_UPD_RD,
    ST_UPD_CMP,
    ST_UPD_WR,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                     ok;
    logic [OL_DATA_WIDTH-1:0] cost;
    logic [OL_ADDR_WIDTH-1:0] slot;
  } rsp_t;

endpackage

// File: rtl/open_list_if.sv
// Command/response channel between the A* search FSM (master) and the
// open-list controller (slave), plus occupancy status.
interface open_list_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();
  import open_list_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  op_e                   cmd_op;
  logic [DATA_WIDTH-1:0] cmd_cost;
  logic [ADDR_WIDTH-1:0] cmd_slot;
  logic                  rsp_valid;
  logic                  rsp_ok;
  logic [DATA_WIDTH-1:0] rsp_cost;
  logic [ADDR_WIDTH-1:0] rsp_slot;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;

  modport master (
    output cmd_valid, cmd_op, cmd_cost, cmd_slot,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_cost, rsp_slot, count, empty, full
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cost, cmd_slot,
    output cmd_ready, rsp_valid, rsp_ok, rsp_cost, rsp_slot, count, empty, full
  );
endinterface

// File: rtl/free_slot_enc.sv
// Lowest-zero priority encoder over the slot valid bitmap; picks the slot an
// INSERT will occupy.
module free_slot_enc #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] i_valid,
  output logic [ADDR_WIDTH-1:0]      o_slot,
  output logic                       o_any_free
);
  localparam int N = 1 << ADDR_WIDTH;

  // Walking downwards lets the lowest free index win.
  always_comb begin
    o_slot     = '0;
    o_any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_slot     = ADDR_WIDTH'(i);
        o_any_free = 1'b1;
      end
    end
  end
endmodule

// File: rtl/open_list_ctrl.sv
// A* open list built on one updateQueue memory: valid bitmap + count, with
// INSERT, POP_MIN (linear scan), UPDATE (decrease-key) and CLEAR commands.
module open_list_ctrl
  import open_list_pkg::*;
#(
  parameter int DATA_WIDTH = OL_DATA_WIDTH,
  parameter int ADDR_WIDTH = OL_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  open_list_if.slave            cmd_if,
  output logic [DATA_WIDTH-1:0] o_mem_data_in,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write_en,
  input  logic [DATA_WIDTH-1:0] i_mem_data_out,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr_out
);
  localparam int N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_NM1   = (ADDR_WIDTH+1)'(N - 1);

  state_e                r_state;
  logic [N-1:0]          r_valid;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_ok;
  logic [DATA_WIDTH-1:0] r_rsp_cost;
  logic [ADDR_WIDTH-1:0] r_rsp_slot;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_slot;
  logic [DATA_WIDTH-1:0] r_new_cost;
  logic [DATA_WIDTH-1:0] r_old_cost;
  logic                  r_upd_less;
  logic                  r_cmp_en;
  logic                  r_best_found;
  logic [DATA_WIDTH-1:0] r_best_cost;
  logic [ADDR_WIDTH-1:0] r_best_slot;

  logic [ADDR_WIDTH-1:0] w_free_slot;
  logic                  w_any_free;
  logic                  w_better;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_win_cost;
  logic [ADDR_WIDTH-1:0] w_win_slot;

  free_slot_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_slot_enc (
    .i_valid    (r_valid),
    .o_slot     (w_free_slot),
    .o_any_free (w_any_free)
  );

  // Strict less-than keeps the earliest (lowest) slot on equal costs.
  assign w_better   = r_valid[i_mem_addr_out] &&
                      (!r_best_found || (i_mem_data_out < r_best_cost));
  assign w_found    = r_best_found || w_better;
  assign w_win_cost = w_better ? i_mem_data_out : r_best_cost;
  assign w_win_slot = w_better ? i_mem_addr_out : r_best_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_ok     <= 1'b0;
      r_rsp_cost   <= '0;
      r_rsp_slot   <= '0;
      r_mem_data   <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_slot       <= '0;
      r_new_cost   <= '0;
      r_old_cost   <= '0;
      r_upd_less   <= 1'b0;
      r_cmp_en     <= 1'b0;
      r_best_found <= 1'b0;
      r_best_cost  <= '0;
      r_best_slot  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_if.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_new_cost  <= cmd_if.cmd_cost;
            case (cmd_if.cmd_op)
              OP_INSERT: begin
                if (!w_any_free) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_ok    <= 1'b0;
                  r_rsp_cost  <= cmd_if.cmd_cost;
                  r_rsp_slot  <= '0;
                end else begin
                  r_state    <= ST_INS_WR;
                  r_slot     <= w_free_slot;
                  r_mem_addr <= w_free_slot;
                  r_mem_data <= cmd_if.cmd_cost;
                  r_mem_we   <= 1'b1;
                end
              end
              OP_POP_MIN: begin
                if (r_empty) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_ok    <= 1'b0;
                  r_rsp_cost  <= '0;
                  r_rsp_slot  <= '0;
                end else begin
                  r_state      <= ST_SCAN;
                  r_mem_addr   <= '0;
                  r_cmp_en     <= 1'b0;
                  r_best_found <= 1'b0;
                end
              end
              OP_UPDATE: begin
                if (!r_valid[cmd_if.cmd_slot]) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_ok    <= 1'b0;
                  r_rsp_cost  <= cmd_if.cmd_cost;
                  r_rsp_slot  <= cmd_if.cmd_slot;
                end else begin
                  r_state    <= ST_UPD_RD;
                  r_slot     <= cmd_if.cmd_slot;
                  r_mem_addr <= cmd_if.cmd_slot;
                end
              end
              OP_CLEAR: begin
                r_state     <= ST_RESP;
                r_valid     <= '0;
                r_count     <= '0;
                r_empty     <= 1'b1;
                r_full      <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_ok    <= 1'b1;
                r_rsp_cost  <= '0;
                r_rsp_slot  <= '0;
              end
            endcase
          end
        end
        ST_INS_WR: begin
          r_mem_we         <= 1'b0;
          r_valid[r_slot]  <= 1'b1;
          r_count          <= r_count + CNT_ONE;
          r_empty          <= 1'b0;
          r_full           <= (r_count == CNT_NM1);
          r_rsp_valid      <= 1'b1;
          r_rsp_ok         <= 1'b1;
          r_rsp_cost       <= r_new_cost;
          r_rsp_slot       <= r_slot;
          r_state          <= ST_RESP;
        end
        ST_SCAN: begin
          // Read data lags the address by one cycle, so the first cycle has nothing to compare.
          r_cmp_en <= 1'b1;
          if (r_cmp_en && w_better) begin
            r_best_found <= 1'b1;
            r_best_cost  <= i_mem_data_out;
            r_best_slot  <= i_mem_addr_out;
          end
          if (r_mem_addr == LAST_SLOT) begin
            r_state <= ST_SCAN_DRAIN;
          end else begin
            r_mem_addr <= r_mem_addr + 1'b1;
          end
        end
        ST_SCAN_DRAIN: begin
          r_rsp_valid <= 1'b1;
          r_rsp_ok    <= w_found;
          r_rsp_cost  <= w_win_cost;
          r_rsp_slot  <= w_win_slot;
          if (w_found) begin
            r_valid[w_win_slot] <= 1'b0;
            r_count             <= r_count - CNT_ONE;
            r_full              <= 1'b0;
            r_empty             <= (r_count == CNT_ONE);
          end
          r_state <= ST_RESP;
        end
        ST_UPD_RD: begin
          r_state <= ST_UPD_CMP;
        end
        ST_UPD_CMP: begin
          r_old_cost <= i_mem_data_out;
          r_upd_less <= (r_new_cost < i_mem_data_out);
          r_mem_we   <= (r_new_cost < i_mem_data_out);
          r_mem_data <= r_new_cost;
          r_state    <= ST_UPD_WR;
        end
        ST_UPD_WR: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_ok    <= r_upd_less;
          r_rsp_cost  <= r_upd_less ? r_new_cost : r_old_cost;
          r_rsp_slot  <= r_slot;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_if.cmd_ready = r_cmd_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_ok    = r_rsp_ok;
  assign cmd_if.rsp_cost  = r_rsp_cost;
  assign cmd_if.rsp_slot  = r_rsp_slot;
  assign cmd_if.count     = r_count;
  assign cmd_if.empty     = r_empty;
  assign cmd_if.full      = r_full;
  assign o_mem_data_in    = r_mem_data;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_write_en   = r_mem_we;
endmodule

// File: tb/tb_open_list_ctrl.sv
// Directed bench for open_list_ctrl with a behavioural updateQueue memory and
// a response scoreboard.
module tb_open_list_ctrl;
  import open_list_pkg::*;

  localparam int DW = OL_DATA_WIDTH;
  localparam int AW = OL_ADDR_WIDTH;
  localparam int N  = 1 << AW;

  typedef struct {
    rsp_t rsp;
    int   lat;
    bit   chk_data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_addr;
  logic          mem_write_en;
  logic [DW-1:0] mem_data_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem [N];

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  logic [N-1:0] tb_valid;

  open_list_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cmd_if ();

  open_list_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_if         (cmd_if),
    .o_mem_data_in  (mem_data_in),
    .o_mem_addr     (mem_addr),
    .o_mem_write_en (mem_write_en),
    .i_mem_data_out (mem_data_out),
    .i_mem_addr_out (mem_addr_out)
  );

  always #5 clk = ~clk;

  // updateQueue stand-in: registered read of the address presented last cycle.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
    mem_addr_out <= mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (!v[i]) return i;
    return 0;
  endfunction

  task automatic send(input op_e op, input logic [DW-1:0] cost, input logic [AW-1:0] slot,
                      input bit e_ok, input logic [DW-1:0] e_cost, input logic [AW-1:0] e_slot,
                      input int e_lat, input bit chk_data);
    exp_t e;
    int k;
    bit seen;
    int wr_cnt;
    int wr_cyc;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    e.rsp.ok = e_ok;
    e.rsp.cost = e_cost;
    e.rsp.slot = e_slot;
    e.lat = e_lat;
    e.chk_data = chk_data;
    exp_q.push_back(e);
    k = 0;
    while (!cmd_if.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", 32'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cost  = cost;
    cmd_if.cmd_slot  = slot;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    seen = 0; k = 0; wr_cnt = 0; wr_cyc = 0; wr_a = '0; wr_d = '0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (mem_write_en) begin
        wr_cnt++; wr_cyc = k; wr_a = mem_addr; wr_d = mem_data_in;
      end
      if (k == 1) check("ready_busy", 32'(cmd_if.cmd_ready), 0);
      if (cmd_if.rsp_valid) seen = 1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL rsp_timeout observed=none expected=cycle %0d", e.lat);
    end else begin
      check("rsp_latency", 32'(k), 32'(e.lat));
      check("rsp_ok", 32'(cmd_if.rsp_ok), 32'(e.rsp.ok));
      if (e.chk_data) begin
        check("rsp_cost", 32'(cmd_if.rsp_cost), 32'(e.rsp.cost));
        check("rsp_slot", 32'(cmd_if.rsp_slot), 32'(e.rsp.slot));
      end
      @(negedge clk);
      check("ready_after", 32'(cmd_if.cmd_ready), 1);
    end
    if ((op == OP_INSERT || op == OP_UPDATE) && e_ok) begin
      check("mem_wr_count", 32'(wr_cnt), 1);
      check("mem_wr_cycle", 32'(wr_cyc), (op == OP_INSERT) ? 1 : 3);
      check("mem_wr_addr", 32'(wr_a), 32'(e_slot));
      check("mem_wr_data", 32'(wr_d), 32'(e_cost));
    end else begin
      check("mem_wr_none", 32'(wr_cnt), 0);
    end
    $display("txn op=%s cost=%0d slot=%0d -> ok=%0d cost=%0d slot=%0d lat=%0d count=%0d",
             op.name(), cost, slot, cmd_if.rsp_ok, cmd_if.rsp_cost, cmd_if.rsp_slot, k, cmd_if.count);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < N; i++) mem[i] = '0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_INSERT;
    cmd_if.cmd_cost  = '0;
    cmd_if.cmd_slot  = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(cmd_if.cmd_ready), 1);
    check("reset_empty", 32'(cmd_if.empty), 1);
    check("reset_full", 32'(cmd_if.full), 0);
    check("reset_count", 32'(cmd_if.count), 0);
    check("reset_rsp_valid", 32'(cmd_if.rsp_valid), 0);
    check("reset_mem_we", 32'(mem_write_en), 0);

    send(OP_INSERT, 9, 0, 1, 9, 0, 2, 1);
    send(OP_INSERT, 3, 0, 1, 3, 1, 2, 1);
    send(OP_INSERT, 7, 0, 1, 7, 2, 2, 1);
    send(OP_INSERT, 3, 0, 1, 3, 3, 2, 1);
    check("count_after_4", 32'(cmd_if.count), 4);
    send(OP_POP_MIN, 0, 0, 1, 3, 1, 18, 1);
    send(OP_POP_MIN, 0, 0, 1, 3, 3, 18, 1);
    check("count_after_pops", 32'(cmd_if.count), 2);
    send(OP_INSERT, 5, 0, 1, 5, 1, 2, 1);

    // Slots 0,1,2 now hold 9,5,7.
    send(OP_UPDATE, 4, 0, 1, 4, 0, 4, 1);
    send(OP_UPDATE, 6, 0, 0, 4, 0, 4, 1);
    send(OP_UPDATE, 1, 5, 0, 0, 0, 1, 0);
    send(OP_POP_MIN, 0, 0, 1, 4, 0, 18, 1);

    tb_valid = 16'b0000_0000_0000_0110;
    for (int i = 0; i < 14; i++) begin
      int s;
      s = lowest_free(tb_valid);
      send(OP_INSERT, DW'(30 + i), 0, 1, DW'(30 + i), AW'(s), 2, 1);
      tb_valid[s] = 1'b1;
    end
    check("full_flag", 32'(cmd_if.full), 1);
    check("full_count", 32'(cmd_if.count), 16);
    send(OP_INSERT, 99, 0, 0, 0, 0, 1, 0);
    check("count_after_reject", 32'(cmd_if.count), 16);

    send(OP_CLEAR, 0, 0, 1, 0, 0, 1, 0);
    check("clear_count", 32'(cmd_if.count), 0);
    check("clear_empty", 32'(cmd_if.empty), 1);
    check("clear_full", 32'(cmd_if.full), 0);
    send(OP_POP_MIN, 0, 0, 0, 0, 0, 1, 0);
    send(OP_INSERT, 11, 0, 1, 11, 0, 2, 1);
    send(OP_INSERT, 12, 0, 1, 12, 1, 2, 1);
    send(OP_INSERT, 13, 0, 1, 13, 2, 2, 1);
    send(OP_CLEAR, 0, 0, 1, 0, 0, 1, 0);
    check("clear2_count", 32'(cmd_if.count), 0);
    check("clear2_empty", 32'(cmd_if.empty), 1);
    send(OP_POP_MIN, 0, 0, 0, 0, 0, 1, 0);

    // Reset in the middle of a scan.
    send(OP_INSERT, 21, 0, 1, 21, 0, 2, 1);
    send(OP_INSERT, 22, 0, 1, 22, 1, 2, 1);
    check("pre_abort_ready", 32'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_POP_MIN;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("scan_addr_cycle8", 32'(mem_addr), 7);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(cmd_if.cmd_ready), 1);
    check("abort_empty", 32'(cmd_if.empty), 1);
    check("abort_count", 32'(cmd_if.count), 0);
    check("abort_rsp_valid", 32'(cmd_if.rsp_valid), 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
    check("abort_mem_we", 32'(mem_write_en), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cmd_if.rsp_valid) pulses++;
    end
    check("abort_no_rsp", 32'(pulses), 0);
    check("abort_empty_after", 32'(cmd_if.empty), 1);
    $display("txn op=RESET_MID_POP rsp_pulses=%0d count=%0d", pulses, cmd_if.count);
    send(OP_POP_MIN, 0, 0, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
